// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : video_timing_gen
// Brief    : Raster timing and pixel-coordinate generator; realigns RGB from a
//            fixed-latency pixel source with sync/de delayed by PIPE_DELAY.
//            Optional internal test pattern when TEST_PATTERN_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module video_timing_gen #(
    parameter int   H_ACTIVE   = 1280,
    parameter int   H_FP       = 110,
    parameter int   H_SYNC     = 40,
    parameter int   H_BP       = 220,
    parameter int   V_ACTIVE   = 720,
    parameter int   V_FP       = 5,
    parameter int   V_SYNC     = 5,
    parameter int   V_BP       = 20,
    parameter logic HSYNC_POL  = 1'b1,
    parameter logic VSYNC_POL  = 1'b1,
    parameter int   PIPE_DELAY = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        pix_req,
    input  logic [7:0]  red_in,
    input  logic [7:0]  green_in,
    input  logic [7:0]  blue_in,
`ifdef TEST_PATTERN_EN
    input  logic        pattern_en,
`endif
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        frame_start
);

    localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] c_h_max    = 12'(c_h_total - 1);
    localparam logic [11:0] c_v_max    = 12'(c_v_total - 1);
    // 13-bit bounds so a total of exactly 4096 still compares correctly
    localparam logic [12:0] c_h_act    = 13'(H_ACTIVE);
    localparam logic [12:0] c_v_act    = 13'(V_ACTIVE);
    localparam logic [12:0] c_hs_beg   = 13'(H_ACTIVE + H_FP);
    localparam logic [12:0] c_hs_end   = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [12:0] c_vs_beg   = 13'(V_ACTIVE + V_FP);
    localparam logic [12:0] c_vs_end   = 13'(V_ACTIVE + V_FP + V_SYNC);

    // timing word: {frame_start, de, vsync, hsync}
    localparam logic [3:0]  c_tim_rst  = {1'b0, 1'b0, ~VSYNC_POL, ~HSYNC_POL};

    logic [11:0] r_h;
    logic [11:0] r_v;
    logic        r_pix_req;
    logic [11:0] w_h_nxt;
    logic [11:0] w_v_nxt;
    logic        w_hs_act;
    logic        w_vs_act;
    logic [3:0]  w_tim_now;
    logic [3:0]  r_tim [0:PIPE_DELAY-1];
    logic        w_de_pre;
    logic [23:0] w_rgb_src;
    logic [23:0] r_rgb;

    always_comb begin
        w_h_nxt = r_h + 12'd1;
        w_v_nxt = r_v;
        if (r_h == c_h_max) begin
            w_h_nxt = '0;
            w_v_nxt = (r_v == c_v_max) ? 12'd0 : r_v + 12'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_h       <= '0;
            r_v       <= '0;
            r_pix_req <= 1'b1;
        end else if (enable) begin
            r_h       <= w_h_nxt;
            r_v       <= w_v_nxt;
            r_pix_req <= ({1'b0, w_h_nxt} < c_h_act) && ({1'b0, w_v_nxt} < c_v_act);
        end
    end

    assign w_hs_act  = ({1'b0, r_h} >= c_hs_beg) && ({1'b0, r_h} < c_hs_end);
    assign w_vs_act  = ({1'b0, r_v} >= c_vs_beg) && ({1'b0, r_v} < c_vs_end);
    assign w_tim_now = {(r_h == 12'd0) && (r_v == 12'd0),
                        r_pix_req,
                        w_vs_act ? VSYNC_POL : ~VSYNC_POL,
                        w_hs_act ? HSYNC_POL : ~HSYNC_POL};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < PIPE_DELAY; i++) r_tim[i] <= c_tim_rst;
        end else if (enable) begin
            r_tim[0] <= w_tim_now;
            for (int i = 1; i < PIPE_DELAY; i++) r_tim[i] <= r_tim[i-1];
        end
    end

    // de one stage ahead of the outputs decides whether the RGB register loads or blanks
    generate
        if (PIPE_DELAY == 1) begin : g_pre_now
            assign w_de_pre = w_tim_now[2];
        end else begin : g_pre_pipe
            assign w_de_pre = r_tim[PIPE_DELAY-2][2];
        end
    endgenerate

`ifdef TEST_PATTERN_EN
    logic [15:0] w_xy_pre;

    // coordinates travel alongside the timing so the pattern matches its own x/y
    generate
        if (PIPE_DELAY == 1) begin : g_xy_now
            assign w_xy_pre = {r_h[7:0], r_v[7:0]};
        end else begin : g_xy_pipe
            logic [15:0] r_xy [0:PIPE_DELAY-2];
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < PIPE_DELAY-1; i++) r_xy[i] <= '0;
                end else if (enable) begin
                    r_xy[0] <= {r_h[7:0], r_v[7:0]};
                    for (int i = 1; i < PIPE_DELAY-1; i++) r_xy[i] <= r_xy[i-1];
                end
            end
            assign w_xy_pre = r_xy[PIPE_DELAY-2];
        end
    endgenerate

    always_comb begin
        w_rgb_src = {red_in, green_in, blue_in};
        if (pattern_en) begin
            w_rgb_src = {w_xy_pre[15:8], w_xy_pre[7:0], w_xy_pre[15:8] ^ w_xy_pre[7:0]};
        end
    end
`else
    assign w_rgb_src = {red_in, green_in, blue_in};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rgb <= '0;
        end else if (enable) begin
            r_rgb <= w_de_pre ? w_rgb_src : 24'd0;
        end
    end

    assign x       = r_h;
    assign y       = r_v;
    assign pix_req = r_pix_req;
    assign {frame_start, de, vsync, hsync} = r_tim[PIPE_DELAY-1];
    assign {red, green, blue} = r_rgb;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_timing_gen
// Brief    : Self-checking bench for video_timing_gen on a tiny 8x6 raster.
//            Exercises the pattern path when TEST_PATTERN_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_video_timing_gen;

    localparam int c_pd    = 2;
    localparam int c_htot  = 8;
    localparam int c_frame = 48;

    logic        clk        = 1'b0;
    logic        reset_n    = 1'b0;
    logic        enable     = 1'b0;
    logic        pattern_en = 1'b0;
    logic [7:0]  red_in     = '0;
    logic [7:0]  green_in   = '0;
    logic [7:0]  blue_in    = '0;
    logic [11:0] x, y;
    logic        pix_req, hsync, vsync, de, frame_start;
    logic [7:0]  red, green, blue;

    int   checks = 0;
    int   errors = 0;
    int   n_cnt  = 0;
    logic pe_hist [0:63];

    always #5 clk = ~clk;

    video_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .PIPE_DELAY(c_pd)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .x(x), .y(y), .pix_req(pix_req),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
`ifdef TEST_PATTERN_EN
        .pattern_en(pattern_en),
`endif
        .red(red), .green(green), .blue(blue),
        .hsync(hsync), .vsync(vsync), .de(de), .frame_start(frame_start)
    );

    // model time base: number of enabled clock edges since reset release
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) n_cnt <= 0;
        else if (enable) n_cnt <= n_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] src_pix(input int p);
        int h, v;
        h = p % c_htot;
        v = p / c_htot;
        return {8'(8'h10 + h), 8'(8'h20 + v), 8'(8'hC0 + 4 * v + h)};
    endfunction

    function automatic logic [23:0] pat_pix(input int p);
        int h, v;
        h = p % c_htot;
        v = p / c_htot;
        return {8'(h), 8'(v), 8'(h ^ v)};
    endfunction

    always @(negedge clk) begin
        int p, q, eh, ev;
        logic e_de, e_hs, e_vs, e_fs;
        logic [23:0] e_rgb;
        p = n_cnt % c_frame;
        chk("x", x, p % c_htot);
        chk("y", y, p / c_htot);
        chk("pix_req", pix_req, ((p % c_htot) < 4) && ((p / c_htot) < 3));
        e_de = 1'b0; e_hs = 1'b0; e_vs = 1'b0; e_fs = 1'b0; e_rgb = '0;
        if (n_cnt >= c_pd) begin
            q    = (n_cnt - c_pd) % c_frame;
            eh   = q % c_htot;
            ev   = q / c_htot;
            e_de = (eh < 4) && (ev < 3);
            e_hs = (eh == 5) || (eh == 6);
            e_vs = (ev == 4);
            e_fs = (q == 0);
            if (e_de) e_rgb = pe_hist[(n_cnt - 1) % 64] ? pat_pix(q) : src_pix(q);
        end
        chk("de", de, e_de);
        chk("hsync", hsync, e_hs);
        chk("vsync", vsync, e_vs);
        chk("frame_start", frame_start, e_fs);
        chk("red", red, e_rgb[23:16]);
        chk("green", green, e_rgb[15:8]);
        chk("blue", blue, e_rgb[7:0]);
    end

    // source returns the pixel for the coordinates issued one enabled cycle earlier
    task automatic step(input logic en);
        enable = en;
        pe_hist[n_cnt % 64] = pattern_en;
        {red_in, green_in, blue_in} = (n_cnt >= 1) ? src_pix((n_cnt - 1) % c_frame) : 24'h0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) pe_hist[i] = 1'b0;
        repeat (3) step(1'b0);
        chk("rst_x", x, 0);
        chk("rst_pix_req", pix_req, 1);
        chk("rst_hsync", hsync, 0);
        chk("rst_de", de, 0);

        reset_n = 1'b1;
        for (int k = 0; k < 100; k++) begin
            step(1'b1);
            case (n_cnt)
                1:  chk("lit_x1", x, 1);
                2:  begin
                        chk("lit_fs2", frame_start, 1);
                        chk("lit_red2", red, 8'h10);
                        chk("lit_green2", green, 8'h20);
                        chk("lit_blue2", blue, 8'hC0);
                    end
                5:  chk("lit_red5", red, 8'h13);
                6:  begin chk("lit_de6", de, 0); chk("lit_red6", red, 8'h00); end
                7:  chk("lit_hs7", hsync, 1);
                9:  chk("lit_hs9", hsync, 0);
                34: chk("lit_vs34", vsync, 1);
                41: chk("lit_vs41", vsync, 1);
                42: chk("lit_vs42", vsync, 0);
                50: chk("lit_fs50", frame_start, 1);
                default: ;
            endcase
        end

        while (n_cnt % c_frame != 18) step(1'b1);
        chk("frz_x_start", x, 2);
        repeat (5) begin
            step(1'b0);
            chk("frz_x", x, 2);
        end
        step(1'b1);
        chk("resume_x", x, 3);

        while (n_cnt % c_frame != 38) step(1'b1);
        chk("pre_rst_vsync", vsync, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_x", x, 0);
        chk("arst_y", y, 0);
        chk("arst_pix_req", pix_req, 1);
        chk("arst_hsync", hsync, 0);
        chk("arst_vsync", vsync, 0);
        chk("arst_de", de, 0);
        chk("arst_rgb", {red, green, blue}, 0);
        step(1'b1);
        step(1'b1);
        reset_n = 1'b1;
        repeat (60) step(1'b1);

`ifdef TEST_PATTERN_EN
        while (n_cnt % c_frame != 0) step(1'b1);
        pattern_en = 1'b1;
        repeat (c_frame) begin
            step(1'b1);
            if (n_cnt % c_frame == 21) begin
                chk("pat_red", red, 8'h03);
                chk("pat_green", green, 8'h02);
                chk("pat_blue", blue, 8'h01);
            end
        end
        pattern_en = 1'b0;
        repeat (c_frame) begin
            step(1'b1);
            if (n_cnt % c_frame == 21) begin
                chk("src_red", red, 8'h13);
                chk("src_green", green, 8'h22);
                chk("src_blue", blue, 8'hCB);
            end
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
